// File: rtl/regfile_pkg.sv
// Shared constants for the register-file write-port arbiter.
package regfile_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 32;

    // Requester ids; also the bit position of each requester in the grant vector.
    localparam int unsigned REQ0 = 0;
    localparam int unsigned REQ1 = 1;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_REQ0 = 2'b01;
    localparam logic [1:0] GRANT_REQ1 = 2'b10;

endpackage

// File: rtl/regfile_wr_fifo.sv
// Per-requester write FIFO: address/data storage with push/pop, occupancy count,
// head outputs and per-entry valid/address vectors for hazard comparison.
module regfile_wr_fifo #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [ADDR_W-1:0]            push_addr,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [CNT_W-1:0]             count,
    output logic [ADDR_W-1:0]            head_addr_c,
    output logic [DATA_W-1:0]            head_data_c,
    output logic [DEPTH-1:0]             entry_valid_c,
    output logic [DEPTH-1:0][ADDR_W-1:0] entry_addr_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_mem;
    logic [DEPTH-1:0][DATA_W-1:0] data_mem;
    logic [PTR_W-1:0]             offset;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents need no reset since validity comes from count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    assign head_addr_c  = addr_mem[rd_ptr];
    assign head_data_c  = data_mem[rd_ptr];
    assign entry_addr_c = addr_mem;

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        entry_valid_c = '0;
        offset        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset           = PTR_W'(i) - rd_ptr;
            entry_valid_c[i] = CNT_W'(offset) < count;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between two requesters through per-requester
// FIFOs and a round-robin arbiter, and flags read-after-write hazards on RA1/RA2.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned ZERO_DROP = 1
) (
    input  logic              Input_clk,
    input  logic              Input_rst_n,
    input  logic              Input_req0_valid,
    input  logic [ADDR_W-1:0] Input_req0_addr,
    input  logic [DATA_W-1:0] Input_req0_data,
    output logic              monitor_req0_ready,
    input  logic              Input_req1_valid,
    input  logic [ADDR_W-1:0] Input_req1_addr,
    input  logic [DATA_W-1:0] Input_req1_data,
    output logic              monitor_req1_ready,
    input  logic [ADDR_W-1:0] Input_RA1,
    input  logic [ADDR_W-1:0] Input_RA2,
    output logic              monitor_WE,
    output logic [ADDR_W-1:0] monitor_WA,
    output logic [DATA_W-1:0] monitor_WD,
    output logic [1:0]        monitor_grant,
    output logic              monitor_hazard1,
    output logic              monitor_hazard2
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                         req_valid  [2];
    logic [ADDR_W-1:0]            req_addr   [2];
    logic [DATA_W-1:0]            req_data   [2];
    logic                         ready_c    [2];
    logic                         push_c     [2];
    logic [CNT_W-1:0]             count      [2];
    logic [ADDR_W-1:0]            head_addr  [2];
    logic [DATA_W-1:0]            head_data  [2];
    logic [DEPTH-1:0]             entry_valid[2];
    logic [DEPTH-1:0][ADDR_W-1:0] entry_addr [2];

    logic       rr_ptr;
    logic       rr_ptr_nxt;
    logic [1:0] grant_c;
    logic       hit1;
    logic       hit2;

    assign req_valid[REQ0] = Input_req0_valid;
    assign req_addr[REQ0]  = Input_req0_addr;
    assign req_data[REQ0]  = Input_req0_data;
    assign req_valid[REQ1] = Input_req1_valid;
    assign req_addr[REQ1]  = Input_req1_addr;
    assign req_data[REQ1]  = Input_req1_data;

    assign monitor_req0_ready = ready_c[REQ0];
    assign monitor_req1_ready = ready_c[REQ1];

    // One FIFO per requester; address-0 writes complete the handshake but are not stored.
    for (genvar g = 0; g < 2; g++) begin : g_fifo
        assign ready_c[g] = count[g] < CNT_W'(DEPTH);
        assign push_c[g]  = req_valid[g] && ready_c[g]
                            && !((ZERO_DROP != 0) && (req_addr[g] == '0));

        regfile_wr_fifo #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk           (Input_clk),
            .rst_n         (Input_rst_n),
            .push          (push_c[g]),
            .push_addr     (req_addr[g]),
            .push_data     (req_data[g]),
            .pop           (grant_c[g]),
            .count         (count[g]),
            .head_addr_c   (head_addr[g]),
            .head_data_c   (head_data[g]),
            .entry_valid_c (entry_valid[g]),
            .entry_addr_c  (entry_addr[g])
        );
    end

    // Round-robin grant on the FIFO heads; the pointer names the preferred requester.
    always_comb begin
        grant_c    = GRANT_NONE;
        rr_ptr_nxt = rr_ptr;
        if ((count[REQ0] != '0) && ((count[REQ1] == '0) || (rr_ptr == 1'(REQ0)))) begin
            grant_c    = GRANT_REQ0;
            rr_ptr_nxt = 1'(REQ1);
        end else if (count[REQ1] != '0) begin
            grant_c    = GRANT_REQ1;
            rr_ptr_nxt = 1'(REQ0);
        end
    end

    // Registered write port; WA/WD hold their last values when idle.
    always_ff @(posedge Input_clk or negedge Input_rst_n) begin
        if (!Input_rst_n) begin
            rr_ptr        <= 1'(REQ0);
            monitor_WE    <= 1'b0;
            monitor_WA    <= '0;
            monitor_WD    <= '0;
            monitor_grant <= GRANT_NONE;
        end else begin
            rr_ptr        <= rr_ptr_nxt;
            monitor_WE    <= (grant_c != GRANT_NONE);
            monitor_grant <= grant_c;
            if (grant_c[REQ0]) begin
                monitor_WA <= head_addr[REQ0];
                monitor_WD <= head_data[REQ0];
            end else if (grant_c[REQ1]) begin
                monitor_WA <= head_addr[REQ1];
                monitor_WD <= head_data[REQ1];
            end
        end
    end

    // Hazard when a read address matches any queued entry or the write in flight.
    always_comb begin
        hit1 = monitor_WE && (monitor_WA == Input_RA1);
        hit2 = monitor_WE && (monitor_WA == Input_RA2);
        for (int unsigned g = 0; g < 2; g++) begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                if (entry_valid[g][e] && (entry_addr[g][e] == Input_RA1)) hit1 = 1'b1;
                if (entry_valid[g][e] && (entry_addr[g][e] == Input_RA2)) hit2 = 1'b1;
            end
        end
        if ((ZERO_DROP != 0) && (Input_RA1 == '0)) hit1 = 1'b0;
        if ((ZERO_DROP != 0) && (Input_RA2 == '0)) hit2 = 1'b0;
        monitor_hazard1 = hit1;
        monitor_hazard2 = hit2;
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a behavioural regfile on the write port.
module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r0_valid = 1'b0;
    logic [4:0]  r0_addr = '0;
    logic [31:0] r0_data = '0;
    logic        r0_ready;
    logic        r1_valid = 1'b0;
    logic [4:0]  r1_addr = '0;
    logic [31:0] r1_data = '0;
    logic        r1_ready;
    logic [4:0]  ra1 = 5'd31;
    logic [4:0]  ra2 = 5'd31;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [1:0]  grant;
    logic        hz1;
    logic        hz2;

    logic [31:0] rf [32];

    int n_checks = 0;
    int n_errors = 0;

    // Expected write-port trace for the backpressure stream, one entry per edge.
    int exp_we   [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
    int exp_wa   [9] = '{0, 20, 11, 21, 12, 22, 13, 23, 0};
    int exp_gr   [9] = '{0, 1, 2, 1, 2, 1, 2, 1, 0};
    int exp_rdy0 [9] = '{1, 1, 0, 1, 0, 1, 1, 1, 1};
    int exp_rdy1 [9] = '{1, 0, 1, 0, 1, 1, 1, 1, 1};

    regfile_wr_arbiter dut (
        .Input_clk          (clk),
        .Input_rst_n        (rst_n),
        .Input_req0_valid   (r0_valid),
        .Input_req0_addr    (r0_addr),
        .Input_req0_data    (r0_data),
        .monitor_req0_ready (r0_ready),
        .Input_req1_valid   (r1_valid),
        .Input_req1_addr    (r1_addr),
        .Input_req1_data    (r1_data),
        .monitor_req1_ready (r1_ready),
        .Input_RA1          (ra1),
        .Input_RA2          (ra2),
        .monitor_WE         (we),
        .monitor_WA         (wa),
        .monitor_WD         (wd),
        .monitor_grant      (grant),
        .monitor_hazard1    (hz1),
        .monitor_hazard2    (hz2)
    );

    always #5 clk = ~clk;

    // Regfile commits whatever the arbiter presents.
    always @(posedge clk) begin
        if (we) rf[wa] <= wd;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int i0;
        int i1;
        logic acc0;
        logic acc1;

        // Reset values
        tick();
        chk("rst_we", we, 0);
        chk("rst_wa", wa, 0);
        chk("rst_wd", wd, 0);
        chk("rst_grant", grant, 0);
        chk("rst_hz1", hz1, 0);
        tick();
        rst_n = 1'b1;
        chk("rst_rdy0", r0_ready, 1);
        chk("rst_rdy1", r1_ready, 1);

        // Single write from requester 0
        ra1 = 5'd3;
        ra2 = 5'd31;
        r0_valid = 1'b1;
        r0_addr  = 5'd3;
        r0_data  = 32'hDEADBEEF;
        chk("single_rdy0", r0_ready, 1);
        tick();
        r0_valid = 1'b0;
        chk("single_we_k", we, 0);
        chk("single_hz1_q", hz1, 1);
        tick();
        chk("single_we", we, 1);
        chk("single_wa", wa, 3);
        chk("single_wd", wd, 32'hDEADBEEF);
        chk("single_grant", grant, 2'b01);
        chk("single_hz1_f", hz1, 1);
        tick();
        chk("single_we_off", we, 0);
        chk("single_grant_off", grant, 2'b00);
        chk("single_wa_hold", wa, 3);
        chk("single_rf3", rf[3], 32'hDEADBEEF);
        chk("single_hz1_done", hz1, 0);

        // Contention: two entries per requester pushed on the same edges
        do_reset();
        ra1 = 5'd31;
        r0_valid = 1'b1; r0_addr = 5'd1; r0_data = 32'h0000_0101;
        r1_valid = 1'b1; r1_addr = 5'd9; r1_data = 32'h0000_0109;
        tick();
        chk("cont_we_a", we, 0);
        r0_addr = 5'd2;  r0_data = 32'h0000_0102;
        r1_addr = 5'd10; r1_data = 32'h0000_010A;
        tick();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        chk("cont_g1", grant, 2'b01);
        chk("cont_wa1", wa, 1);
        chk("cont_wd1", wd, 32'h0000_0101);
        chk("cont_rdy1_full", r1_ready, 0);
        tick();
        chk("cont_g2", grant, 2'b10);
        chk("cont_wa2", wa, 9);
        tick();
        chk("cont_g3", grant, 2'b01);
        chk("cont_wa3", wa, 2);
        tick();
        chk("cont_g4", grant, 2'b10);
        chk("cont_wa4", wa, 10);
        chk("cont_wd4", wd, 32'h0000_010A);
        tick();
        chk("cont_idle", we, 0);

        // Backpressure: req0 streams 20..23, req1 offers 11..13
        do_reset();
        i0 = 0;
        i1 = 0;
        for (int e = 0; e < 9; e++) begin
            r0_valid = (i0 < 4);
            r0_addr  = 5'(20 + i0);
            r0_data  = 32'hA000_0000 + 32'(20 + i0);
            r1_valid = (i1 < 3);
            r1_addr  = 5'(11 + i1);
            r1_data  = 32'hA000_0000 + 32'(11 + i1);
            acc0 = r0_valid && r0_ready;
            acc1 = r1_valid && r1_ready;
            tick();
            if (acc0) i0++;
            if (acc1) i1++;
            chk($sformatf("bp_we_e%0d", e + 1), we, exp_we[e]);
            if (exp_we[e] != 0) begin
                chk($sformatf("bp_wa_e%0d", e + 1), wa, exp_wa[e]);
                chk($sformatf("bp_wd_e%0d", e + 1), wd, 32'hA000_0000 + 32'(exp_wa[e]));
            end
            chk($sformatf("bp_gr_e%0d", e + 1), grant, exp_gr[e]);
            chk($sformatf("bp_rdy0_e%0d", e + 1), r0_ready, exp_rdy0[e]);
            chk($sformatf("bp_rdy1_e%0d", e + 1), r1_ready, exp_rdy1[e]);
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        chk("bp_acc0", i0, 4);
        chk("bp_acc1", i1, 3);

        // Zero-address drop
        do_reset();
        ra1 = 5'd0;
        r0_valid = 1'b1;
        r0_addr  = 5'd0;
        r0_data  = 32'h55;
        chk("zero_rdy", r0_ready, 1);
        tick();
        r0_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("zero_we_c%0d", c), we, 0);
            chk($sformatf("zero_hz1_c%0d", c), hz1, 0);
            chk($sformatf("zero_rdy_c%0d", c), r0_ready, 1);
            tick();
        end

        // Hazard tracking of a queued then in-flight write
        do_reset();
        ra1 = 5'd7;
        ra2 = 5'd8;
        r1_valid = 1'b1;
        r1_addr  = 5'd7;
        r1_data  = 32'h0000_0777;
        chk("haz_pre", hz1, 0);
        tick();
        r1_valid = 1'b0;
        chk("haz1_q", hz1, 1);
        chk("haz2_q", hz2, 0);
        chk("haz_we_q", we, 0);
        tick();
        chk("haz_we", we, 1);
        chk("haz_grant", grant, 2'b10);
        chk("haz1_f", hz1, 1);
        chk("haz2_f", hz2, 0);
        tick();
        chk("haz_we_off", we, 0);
        chk("haz1_done", hz1, 0);

        // Async reset with writes queued and one in flight
        do_reset();
        ra1 = 5'd6;
        ra2 = 5'd31;
        r0_valid = 1'b1; r0_addr = 5'd5;  r0_data = 32'h0000_0005;
        r1_valid = 1'b1; r1_addr = 5'd6;  r1_data = 32'h0000_0006;
        tick();
        r0_addr = 5'd4;  r0_data = 32'h0000_0004;
        r1_addr = 5'd12; r1_data = 32'h0000_000C;
        tick();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        chk("ar_we_pre", we, 1);
        chk("ar_wa_pre", wa, 5);
        chk("ar_hz1_pre", hz1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_we", we, 0);
        chk("ar_grant", grant, 2'b00);
        chk("ar_wa", wa, 0);
        chk("ar_hz1", hz1, 0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("ar_rdy0", r0_ready, 1);
        chk("ar_rdy1", r1_ready, 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("ar_we_c%0d", c), we, 0);
            chk($sformatf("ar_grant_c%0d", c), grant, 2'b00);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port (WE/WA/WD) between two independent write requesters, e.g. ALU writeback and load writeback.
- Each requester has its own small FIFO with a valid/ready handshake. A round-robin arbiter drains one entry per cycle into registered write-port outputs.
- Also reports read-after-write hazards: it flags when a register-file read address matches a write that is queued or in flight.
- Sits directly in front of the regfile: its monitor_WE/WA/WD outputs drive the regfile's Input_WE/WA/WD.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- DEPTH, 2, entries per requester FIFO; power of two, at least 2.
- ZERO_DROP, 1, when 1, writes to address 0 are accepted and then discarded.

Ports:
- Input_clk  in  1  clock; all state updates on the rising edge.
- Input_rst_n  in  1  reset, asynchronous assert, active-low.
- Input_req0_valid  in  1  requester 0 has a write.
- Input_req0_addr  in  ADDR_W  requester 0 destination register.
- Input_req0_data  in  DATA_W  requester 0 write data.
- monitor_req0_ready  out  1  requester 0 FIFO can accept.
- Input_req1_valid  in  1  requester 1 has a write.
- Input_req1_addr  in  ADDR_W  requester 1 destination register.
- Input_req1_data  in  DATA_W  requester 1 write data.
- monitor_req1_ready  out  1  requester 1 FIFO can accept.
- Input_RA1  in  ADDR_W  read address 1, used for hazard check.
- Input_RA2  in  ADDR_W  read address 2, used for hazard check.
- monitor_WE  out  1  regfile write enable, registered.
- monitor_WA  out  ADDR_W  regfile write address, registered.
- monitor_WD  out  DATA_W  regfile write data, registered.
- monitor_grant  out  2  one-hot source of the current monitor_WE; 00 when idle.
- monitor_hazard1  out  1  RA1 has a pending write.
- monitor_hazard2  out  1  RA2 has a pending write.

Behaviour:
- Reset (async, Input_rst_n=0):
  - FIFOs empty, counts 0.
  - Round-robin pointer = 0.
  - monitor_WE=0, monitor_WA=0, monitor_WD=0, monitor_grant=00.
  - monitor_req*_ready=1 once reset deasserts; hazards=0.
  - Reset mid-operation discards all queued and in-flight writes; no partial write is issued.
- Handshake:
  - Push on the rising edge where valid&&ready.
  - ready = (count < DEPTH), derived from registered count only.
  - A full FIFO does not accept even in a cycle where it is being popped.
  - valid may drop without an accept; data is sampled only on accept.
- ZERO_DROP=1 and addr==0:
  - The handshake completes normally (ready unaffected).
  - The entry is not enqueued, never produces WE, and never raises a hazard.
- Arbitration, each cycle, combinational on the FIFO heads:
  - Only one FIFO non-empty: grant it.
  - Both non-empty: grant the FIFO the pointer names.
  - On grant to i, pointer <= 1-i at the edge. Pointer holds when there is no grant.
- Output register:
  - At the edge, the granted head pops and loads monitor_WA/WD; monitor_WE<=1; monitor_grant<=one-hot(i).
  - With no grant: monitor_WE<=0, monitor_grant<=00. WA/WD hold their last values.
- Latency and throughput:
  - An entry accepted at edge k into an empty system appears with monitor_WE=1 in the cycle after edge k+1.
  - The regfile commits it at edge k+2.
  - Throughput is one write per cycle total.
- Ordering:
  - Per-requester order is preserved.
  - Across requesters, order follows grant order only.
  - Same address from both requesters is written twice, last grant wins; no merging.
- Simultaneous push and pop on the same FIFO (count<DEPTH): count unchanged and data order preserved.
- FIFO pointers wrap modulo DEPTH.
- Hazard, combinational:
  - monitor_hazardN=1 iff RAN matches the addr of any valid entry in either FIFO, or (monitor_WE && monitor_WA==RAN).
  - RAN==0 never hazards when ZERO_DROP=1.

Decomposition:
- Package regfile_pkg: ADDR_W/DATA_W defaults, requester-id constants REQ0=0 and REQ1=1, and the one-hot grant encodings.
- Sub-module regfile_wr_fifo, instantiated twice:
  - DEPTH x (ADDR_W+DATA_W) storage with push/pop, count, head outputs.
  - Exports the per-entry address and valid vectors for the hazard compare.
- Arbiter, output register and hazard logic stay in the top.

Test Plan:
- Reset then single write: req0 addr=3 data=0xDEADBEEF, one cycle.
  - Required: WE=1, WA=3, WD=0xDEADBEEF, grant=01 exactly one cycle, starting the cycle after the accept edge.
  - Required: a regfile read of RA1=3 returns 0xDEADBEEF afterwards.
- Contention: both requesters valid every cycle, req0 addrs 1,2 and req1 addrs 9,10.
  - Required: grant sequence 01,10,01,10 with WA 1,9,2,10.
- Backpressure: req1 valid with DEPTH=2 while a sustained req0 stream keeps the arbiter busy.
  - Required: req1 ready drops after its FIFO holds 2 entries.
  - Required: a 3rd req1 valid is not accepted until a pop frees a slot, and no data is lost or duplicated.
- Zero drop: req0 addr=0 data=0x55.
  - Required: ready=1, the accept completes, WE never asserts, and hazard1 with RA1=0 stays 0.
- Hazard: queue req1 addr=7, hold RA1=7 and RA2=8.
  - Required: hazard1=1 and hazard2=0 from the accept edge until the cycle after WE deasserts; then hazard1=0.
- Async reset with 2 entries queued, asserted between edges.
  - Required: WE=0 and grant=00 immediately, both readies =1 after release, and no write occurs.
